if_id_queue: RTL and testbench

- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry in-order queue between fetch and decode.
- Each entry holds {pc, inst, predict_result, next_pc}.
- Replaces the Pass/Hold/Bubble stall encoding with valid/ready handshakes on both sides, so fetch can run ahead while decode is stalled.
- Branch mispredict flushes all entries in one cycle. Occupancy is exported to fetch-side throttling logic.

---
 rtl/if_id_queue_pkg.sv | 14 +
 rtl/if_id_queue_mem.sv | 31 +++
 rtl/if_id_queue.sv | 120 ++++++++++++
 tb/tb_if_id_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared widths and entry packing for the fetch-to-decode instruction queue.
package if_id_queue_pkg;

    // Default instruction address bus and instruction bus widths.
    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W      = 32;

    // Entry packing order, LSB first: pc, inst, predict, next_pc.
    // That is, entry = {next_pc, predict, inst, pc}.
    function automatic int entry_width(input int addr_w, input int inst_w);
        return 2 * addr_w + inst_w + 1;
    endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage: DEPTH x WIDTH register array, one synchronous write port,
// one asynchronous read port. Storage is deliberately not reset; the top
// level gates reads with its occupancy counter so stale contents never leak.
module if_id_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 97,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the incoming entry into its slot on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Head entry is read combinationally so decode sees it in the same cycle.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/if_id_queue.sv
// In-order queue between instruction fetch and decode.
//
// Handshake: a transfer happens on a side exactly when its valid and ready
// are both high at a rising clk edge and flush is low. in_ready is a function
// of registered occupancy only (never of out_ready), so a full queue does not
// accept a refill in the same cycle it is popped. out_valid likewise depends
// only on registered occupancy. Flush wins over both transfers.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS_W,
    parameter int INST_W = INST_BUS_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              predict_result_i,
    input  logic [ADDR_W-1:0] next_pc_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              predict_result_o,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = entry_width(ADDR_W, INST_W);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    logic               empty, full;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Full/empty and handshake qualification come from the counter alone.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNT_W'(DEPTH));
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && !full && !flush;
        pop       = !empty && out_ready && !flush;
        wr_entry  = {next_pc_i, predict_result_i, inst_i, pc_i};
    end

    // Next-state for pointers and occupancy; flush returns everything to zero.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointer and counter registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Head entry unpacked and forced to a zero bubble when the queue is empty.
    always_comb begin
        pc_o             = '0;
        inst_o           = '0;
        predict_result_o = 1'b0;
        next_pc_o        = '0;
        if (!empty) begin
            {next_pc_o, predict_result_o, inst_o, pc_o} = rd_entry;
        end
    end

    // Occupancy export for fetch-side throttling.
    always_comb begin
        count       = count_q;
        almost_full = (count_q >= CNT_W'(DEPTH - 1));
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model and a pop-side scoreboard.
module tb_if_id_queue;

    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = 2 * ADDR_W + INST_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] pc_i;
    logic [INST_W-1:0] inst_i;
    logic              predict_result_i;
    logic [ADDR_W-1:0] next_pc_i;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic              predict_result_o;
    logic [ADDR_W-1:0] next_pc_o;
    logic [CNT_W-1:0]  count;
    logic              almost_full;

    if_id_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .pc_i             (pc_i),
        .inst_i           (inst_i),
        .predict_result_i (predict_result_i),
        .next_pc_i        (next_pc_i),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .predict_result_o (predict_result_o),
        .next_pc_o        (next_pc_o),
        .count            (count),
        .almost_full      (almost_full)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    logic [ENTRY_W-1:0] exp_q[$];
    int  mcount  = 0;
    bit  p_push  = 1'b0;
    bit  p_pop   = 1'b0;
    bit  p_flush = 1'b0;
    bit  started = 1'b0;
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: apply the previous cycle's effect to the model,
    // then present new inputs and record what the queue should do with them.
    task automatic drive(input logic v, input logic r, input logic f, input logic [ADDR_W-1:0] pc);
        @(posedge clk);
        #1;
        if (p_flush) mcount = 0;
        else         mcount = mcount + int'(p_push) - int'(p_pop);
        in_valid         = v;
        out_ready        = r;
        flush            = f;
        pc_i             = pc;
        inst_i           = $urandom;
        predict_result_i = 1'($urandom_range(0, 1));
        next_pc_i        = $urandom;
        p_push  = v && (mcount < DEPTH) && !f;
        p_pop   = (mcount != 0) && r && !f;
        p_flush = f;
        if (f) exp_q.delete();
        if (p_push) exp_q.push_back({next_pc_i, predict_result_i, inst_i, pc_i});
    endtask

    // Monitor: checks status against the model and pops on every handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (started && !rst) begin
                check("count", 64'(count), 64'(mcount));
                check("out_valid", 64'(out_valid), 64'(mcount != 0));
                check("in_ready", 64'(in_ready), 64'(mcount < DEPTH));
                check("almost_full", 64'(almost_full), 64'(mcount >= DEPTH - 1));
                if (!out_valid) begin
                    check("bubble_data", {pc_o[15:0], inst_o[15:0], next_pc_o[15:0], 15'd0, predict_result_o},
                          64'd0);
                    check("bubble_full", 64'(pc_o | inst_o | next_pc_o), 64'd0);
                end else if (out_ready && !flush) begin
                    check("pop_has_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        logic [ENTRY_W-1:0] e;
                        e = exp_q.pop_front();
                        check("pop_pc", 64'(pc_o), 64'(e[ADDR_W-1:0]));
                        check("pop_inst", 64'(inst_o), 64'(e[ADDR_W +: INST_W]));
                        check("pop_pred", 64'(predict_result_o), 64'(e[ADDR_W + INST_W]));
                        check("pop_next_pc", 64'(next_pc_o), 64'(e[ENTRY_W-1 -: ADDR_W]));
                    end
                end
            end
        end
    end

    // Main stimulus sequence
    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc_i = '0; inst_i = '0; predict_result_i = 1'b0; next_pc_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;

        // Reset then idle
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_inst_o", 64'(inst_o), 64'd0);
        check("rst_pc_o", 64'(pc_o), 64'd0);

        // Fill without drain
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, ADDR_W'(4 * i));
        drive(1'b0, 1'b0, 1'b0, '0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_almost_full", 64'(almost_full), 64'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h10);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("fifth_push_pc_o", 64'(pc_o), 64'h0);
        check("fifth_push_count", 64'(count), 64'd4);

        // Full with simultaneous pop: no same-cycle refill
        drive(1'b1, 1'b1, 1'b0, 32'h14);
        check("full_pop_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h18);
        check("full_pop_count", 64'(count), 64'd3);
        check("full_pop_head", 64'(pc_o), 64'h04);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("refill_count", 64'(count), 64'd4);

        // Flush with concurrent traffic at count=3
        drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 32'h20);
        check("pre_flush_count", 64'(count), 64'd3);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_inst_o", 64'(inst_o), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h200);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("post_flush_pc_o", 64'(pc_o), 64'h200);
        repeat (2) drive(1'b0, 1'b1, 1'b0, '0);

        // Streaming: one cycle latency, steady count of one
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, ADDR_W'(32'h100 + 4 * i));
            if (i >= 1) begin
                check("stream_count", 64'(count), 64'd1);
                check("stream_pc_o", 64'(pc_o), 64'(32'h100 + 4 * (i - 1)));
            end
        end
        repeat (2) drive(1'b0, 1'b1, 1'b0, '0);

        // Pointer wrap: ten entries through a four-deep queue
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, ADDR_W'(32'h300 + 4 * i));
        repeat (2) drive(1'b0, 1'b1, 1'b0, '0);

        // Asynchronous reset mid-cycle at count=2
        drive(1'b1, 1'b0, 1'b0, 32'h400);
        drive(1'b1, 1'b0, 1'b0, 32'h404);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("pre_rst_count", 64'(count), 64'd2);
        check("pre_rst_pc_o", 64'(pc_o), 64'h400);
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_pc_o", 64'(pc_o), 64'd0);
        check("async_rst_inst_o", 64'(inst_o), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        mcount = 0; p_push = 1'b0; p_pop = 1'b0; p_flush = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0), ADDR_W'($urandom & 32'hffff_fffc));
        end
        repeat (DEPTH + 2) drive(1'b0, 1'b1, 1'b0, '0);
        check("final_count", 64'(count), 64'd0);
        check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
